// File: rtl/instr_sequencer_if.sv
// Host-side bus of the program sequencer: buffer load, playback
// control and the registered instruction stream to the CPU.
interface instr_sequencer_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PTR_BITS    = 4
);
  logic                   load_en;
  logic [PTR_BITS-1:0]    load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   start;
  logic [PTR_BITS:0]      prog_len;
  logic                   repeat_en;
  logic                   halt;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   issue_strobe;
  logic [PTR_BITS-1:0]    pc;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output load_en, load_addr, load_data,
    output start, prog_len, repeat_en, halt,
    input  instruction, issue_strobe, pc,
    input  busy, done, err
  );

  modport slave (
    input  load_en, load_addr, load_data,
    input  start, prog_len, repeat_en, halt,
    output instruction, issue_strobe, pc,
    output busy, done, err
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: buffers a short program and issues each entry
// on a registered bus for a fixed hold time, one-shot or looping.
module instr_sequencer #(
  parameter int INSTR_WIDTH  = 20,
  parameter int PROG_DEPTH   = 16,
  parameter int PTR_BITS     = 4,
  parameter int ISSUE_CYCLES = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);
  localparam int CW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ISSUE_CYCLES - 1);
  localparam logic [PTR_BITS:0] DEPTH = (PTR_BITS + 1)'(PROG_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;
  logic [INSTR_WIDTH-1:0] mem [PROG_DEPTH];
  logic [PTR_BITS-1:0] pc, pc_n, pc_inc;
  logic [PTR_BITS:0] len, len_n;
  logic rep, rep_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [INSTR_WIDTH-1:0] instr, instr_n;
  logic strobe, strobe_n;
  logic busy, busy_n;
  logic done, done_n;
  logic err, err_n;
  logic wr, len_ok, is_last;

  assign pc_inc  = pc + 1'b1;
  assign len_ok  = (bus.prog_len != '0) && (bus.prog_len <= DEPTH);
  assign is_last = ({1'b0, pc} >= (len - 1'b1));

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    cnt_n    = cnt;
    len_n    = len;
    rep_n    = rep;
    instr_n  = NOP_INSTR;
    strobe_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = done;
    err_n    = 1'b0;
    wr       = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.halt) begin
          state_n = IDLE;
          pc_n    = '0;
          cnt_n   = '0;
        end else if (cnt != LAST) begin
          cnt_n   = cnt + 1'b1;
          instr_n = mem[pc];
          busy_n  = 1'b1;
        end else begin
          cnt_n = '0;
          if (!is_last) begin
            pc_n     = pc_inc;
            instr_n  = mem[pc_inc];
            strobe_n = 1'b1;
            busy_n   = 1'b1;
          end else if (rep) begin
            pc_n     = '0;
            instr_n  = mem[0];
            strobe_n = 1'b1;
            busy_n   = 1'b1;
          end else begin
            state_n = DONE;
            pc_n    = '0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        // loads win over nothing else: they need start low
        if (bus.load_en && !bus.start) begin
          wr = 1'b1;
          if (state == DONE) begin
            state_n = IDLE;
            done_n  = 1'b0;
          end
        end else if (bus.start && !bus.halt) begin
          if (len_ok) begin
            state_n  = RUN;
            pc_n     = '0;
            cnt_n    = '0;
            len_n    = bus.prog_len;
            rep_n    = bus.repeat_en;
            done_n   = 1'b0;
            instr_n  = mem[0];
            strobe_n = 1'b1;
            busy_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      cnt    <= '0;
      len    <= '0;
      rep    <= 1'b0;
      instr  <= NOP_INSTR;
      strobe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      cnt    <= cnt_n;
      len    <= len_n;
      rep    <= rep_n;
      instr  <= instr_n;
      strobe <= strobe_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= NOP_INSTR;
    end else if (wr) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.instruction  = instr;
  assign bus.issue_strobe = strobe;
  assign bus.pc           = pc;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table plus hand-built
// loop, halt, load-while-busy and reset-mid-run sequences.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if #(.INSTR_WIDTH(20), .PTR_BITS(4)) bus ();

  instr_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        ld;
    logic [3:0]  addr;
    logic [19:0] data;
    logic        st;
    logic [4:0]  len;
    logic        rep;
    logic        hlt;
    logic [19:0] ei;
    logic        es;
    logic [3:0]  ep;
    logic        eb;
    logic        ed;
    logic        ee;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  logic [19:0] prog [4];

  function automatic vec_t mk(
    logic ld, logic [3:0] addr, logic [19:0] data,
    logic st, logic [4:0] len, logic rep, logic hlt,
    logic [19:0] ei, logic es, logic [3:0] ep,
    logic eb, logic ed, logic ee);
    vec_t v;
    v.ld = ld; v.addr = addr; v.data = data;
    v.st = st; v.len = len; v.rep = rep; v.hlt = hlt;
    v.ei = ei; v.es = es; v.ep = ep;
    v.eb = eb; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  function automatic vec_t vi(
    logic [19:0] ei, logic es, logic [3:0] ep,
    logic eb, logic ed, logic ee);
    return mk(0, 0, 0, 0, 0, 0, 0, ei, es, ep, eb, ed, ee);
  endfunction

  task automatic chk(string tag, int idx, string f,
                     logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %h expected %h",
               tag, idx, f, got, exp);
    end
  endtask

  task automatic apply(string tag, int idx, vec_t v);
    bus.load_en   = v.ld;
    bus.load_addr = v.addr;
    bus.load_data = v.data;
    bus.start     = v.st;
    bus.prog_len  = v.len;
    bus.repeat_en = v.rep;
    bus.halt      = v.hlt;
    @(posedge clk);
    #1;
    chk(tag, idx, "instruction", 32'(bus.instruction), 32'(v.ei));
    chk(tag, idx, "strobe", 32'(bus.issue_strobe), 32'(v.es));
    chk(tag, idx, "pc", 32'(bus.pc), 32'(v.ep));
    chk(tag, idx, "busy", 32'(bus.busy), 32'(v.eb));
    chk(tag, idx, "done", 32'(bus.done), 32'(v.ed));
    chk(tag, idx, "err", 32'(bus.err), 32'(v.ee));
  endtask

  // expected output of a non-looping 3-entry run at cycle c (1..12)
  function automatic vec_t run3(int c, logic [19:0] p0,
                                logic [19:0] p1, logic [19:0] p2);
    logic [19:0] e;
    int k;
    k = (c - 1) / 4;
    e = (k == 0) ? p0 : (k == 1) ? p1 : p2;
    return vi(e, ((c - 1) % 4) == 0, 4'(k), 1, 0, 0);
  endfunction

  initial begin
    prog[0] = 20'h1A001;
    prog[1] = 20'h2B002;
    prog[2] = 20'h3C003;
    prog[3] = 20'h4D004;

    tbl.push_back(mk(1, 0, prog[0], 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, prog[1], 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, prog[2], 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, prog[0], 1, 0, 1, 0, 0));
    for (int c = 2; c <= 12; c++)
      tbl.push_back(run3(c, prog[0], prog[1], prog[2]));
    tbl.push_back(vi(0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 17, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(vi(0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 3, prog[3], 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 17, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vi(0, 0, 0, 0, 0, 0));

    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
    bus.start = 0; bus.prog_len = 0; bus.repeat_en = 0; bus.halt = 0;
    rst = 1'b1;
    @(posedge clk);
    apply("reset", 0, vi(0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) apply("table", i, tbl[i]);

    // looping two-entry program, halted at cycle 10
    apply("loop", 1, mk(0, 0, 0, 1, 2, 1, 0, prog[0], 1, 0, 1, 0, 0));
    for (int c = 2; c <= 10; c++) begin
      int k;
      k = ((c - 1) / 4) % 2;
      apply("loop", c, vi(prog[k], ((c - 1) % 4) == 0, 4'(k), 1, 0, 0));
    end
    apply("halt", 11, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // write during RUN must not reach the buffer
    apply("ldbusy", 1, mk(0, 0, 0, 1, 3, 0, 0, prog[0], 1, 0, 1, 0, 0));
    apply("ldbusy", 2, mk(1, 1, 20'h0FFFF, 0, 0, 0, 0, prog[0], 0, 0, 1, 0, 0));
    for (int c = 3; c <= 12; c++)
      apply("ldbusy", c, run3(c, prog[0], prog[1], prog[2]));
    apply("ldbusy", 13, vi(0, 0, 0, 0, 1, 0));
    apply("rerun", 1, mk(0, 0, 0, 1, 3, 0, 0, prog[0], 1, 0, 1, 0, 0));
    for (int c = 2; c <= 12; c++)
      apply("rerun", c, run3(c, prog[0], prog[1], prog[2]));
    apply("rerun", 13, vi(0, 0, 0, 0, 1, 0));

    // reset sampled at edge 6 of a run
    apply("rstrun", 1, mk(0, 0, 0, 1, 3, 0, 0, prog[0], 1, 0, 1, 0, 0));
    for (int c = 2; c <= 6; c++)
      apply("rstrun", c, run3(c, prog[0], prog[1], prog[2]));
    rst = 1'b1;
    apply("rstrun", 7, vi(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    apply("cleared", 1, mk(0, 0, 0, 1, 1, 0, 0, 20'h00000, 1, 0, 1, 0, 0));
    for (int c = 2; c <= 4; c++)
      apply("cleared", c, vi(20'h00000, 0, 0, 1, 0, 0));
    apply("cleared", 5, vi(0, 0, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that feeds the 20-bit `instruction` input of the simple CPU. A host loads a short program into an internal instruction buffer, then pulses `start`. The block issues each instruction on a registered bus, holding it for a fixed number of cycles so the CU/ALU/data-memory path can complete. It supports one-shot or looping playback, and halt.

## Interface
- `INSTR_WIDTH`, 20, instruction width (matches CPU).
- `PROG_DEPTH`, 16, instruction buffer entries.
- `PTR_BITS`, 4, log2(`PROG_DEPTH`).
- `ISSUE_CYCLES`, 4, cycles each instruction is held on `instruction`; legal range is ≥1.
- `NOP_INSTR`, 20'h00000, value driven when no program instruction is active.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_en`  in  1  write `load_data` to buffer[`load_addr`].
- `load_addr`  in  `PTR_BITS`  buffer write address.
- `load_data`  in  `INSTR_WIDTH`  instruction to store.
- `start`  in  1  begin playback from entry 0.
- `prog_len`  in  `PTR_BITS`+1  number of entries to play; legal range 1..`PROG_DEPTH`; sampled on `start`.
- `repeat_en`  in  1  loop program; sampled on `start`.
- `halt`  in  1  abort playback.
- `instruction`  out  `INSTR_WIDTH`  registered instruction to CPU.
- `issue_strobe`  out  1  high in the first cycle of each issued instruction.
- `pc`  out  `PTR_BITS`  index of the instruction currently on `instruction`.
- `busy`  out  1  playback active.
- `done`  out  1  one-shot program completed (level).
- `err`  out  1  one-cycle pulse on an illegal `start`.

## Operation
- States: IDLE, RUN, DONE.
- Buffer: `PROG_DEPTH` x `INSTR_WIDTH` registers, cleared to `NOP_INSTR` on reset.
  - `load_en` is honoured only in IDLE/DONE and only when `start` is low.
  - Otherwise `load_en` is ignored.
- IDLE/DONE with `start`=1 and `halt`=0:
  - `prog_len` in 1..`PROG_DEPTH`: latch length and `repeat_en`, pc=0, hold counter=0, go to RUN, clear `done`.
  - Otherwise: `err` pulses for 1 cycle, state is unchanged, `done` is unchanged.
- DONE with `load_en` accepted: clear `done` and go to IDLE.
- RUN:
  - `instruction` = buffer[pc].
  - Hold counter counts 0..`ISSUE_CYCLES`-1.
  - `issue_strobe` = (counter==0).
  - At counter=`ISSUE_CYCLES`-1:
    - If pc < len-1: pc+1.
    - Else if latched repeat: pc wraps to 0.
    - Else: go to DONE.
- `halt`=1 in RUN: go to IDLE at the next edge, pc=0, `done` stays 0. `halt` overrides `start` in every state.
- `start` during RUN is ignored.
- Outputs in IDLE/DONE: `instruction`=`NOP_INSTR`, `issue_strobe`=0, `busy`=0.
- Reset values: state IDLE, `instruction`=`NOP_INSTR`, `pc`=0, `busy`=0, `done`=0, `err`=0, `issue_strobe`=0.
- `rst` mid-RUN aborts immediately. The buffer is cleared as well.

## Timing
- All outputs are registered.
- `start` sampled at edge T:
  - From cycle T+1: `instruction`=buffer[0], `issue_strobe`=1, `busy`=1.
- Each instruction is held exactly `ISSUE_CYCLES` cycles. Consecutive instructions are back-to-back with no NOP gap.
- One-shot length L:
  - `busy` is high for L×`ISSUE_CYCLES` cycles.
  - In the following cycle: `instruction`=`NOP_INSTR`, `done`=1.
- Looping: after the last hold cycle of entry len-1, the next cycle shows entry 0 with `issue_strobe`=1.
- `halt` sampled at edge H: from H+1, `instruction`=`NOP_INSTR`, `busy`=0.
- `err` is high in cycle T+1 only.
- With `ISSUE_CYCLES`=1, `issue_strobe` is high every RUN cycle.

## Test plan
- One-shot: load 0x1A001, 0x2B002, 0x3C003 at addresses 0–2, `prog_len`=3, `ISSUE_CYCLES`=4, `start` at cycle 0 ->
  - 0x1A001 in cycles 1–4, 0x2B002 in 5–8, 0x3C003 in 9–12.
  - Strobes at 1, 5, 9.
  - Cycle 13: NOP, `busy`=0, `done`=1.
- Loop: `prog_len`=2, `repeat_en`=1 -> pc sequence 0,1,0,1…, `done` never set. `halt` at cycle 10 -> cycle 11: NOP, `busy`=0, `pc`=0, `done`=0.
- Illegal start: `prog_len`=0, then `prog_len`=17 -> `err` pulses once for each, state stays IDLE, `instruction`=NOP.
- Load while busy: write 0x0FFFF to addr 1 during RUN -> ignored. A rerun issues the original 0x2B002 at pc=1.
- Reset mid-RUN at cycle 6 -> cycle 7: all outputs at reset values. A subsequent `start` with `prog_len`=1 issues 0x00000 (buffer cleared).
- `halt` and `start` in the same cycle in IDLE -> stays IDLE, `busy`=0, no `err`.
